// File: rtl/algo_2rw_b740_t1_mem.sv
// Behavioural t1 physical-memory responder for the 2rw b740 core: NUMVBNK dual-port
// banks with bit-write, fixed DELAY read latency, post-reset zero sweep and sticky protocol errors.
module algo_2rw_b740_t1_mem #(
    parameter int NUMVBNK = 4,
    parameter int BITVBNK = 2,
    parameter int NUMSROW = 4096,
    parameter int BITSROW = 12,
    parameter int PHYWDTH = 128,
    parameter int DELAY   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUMVBNK-1:0]           t1_readA,
    input  logic [NUMVBNK-1:0]           t1_readB,
    input  logic [NUMVBNK-1:0]           t1_writeA,
    input  logic [NUMVBNK-1:0]           t1_writeB,
    input  logic [NUMVBNK*BITSROW-1:0]   t1_addrA,
    input  logic [NUMVBNK*BITSROW-1:0]   t1_addrB,
    input  logic [NUMVBNK*PHYWDTH-1:0]   t1_dinA,
    input  logic [NUMVBNK*PHYWDTH-1:0]   t1_dinB,
    input  logic [NUMVBNK*PHYWDTH-1:0]   t1_bwA,
    input  logic [NUMVBNK*PHYWDTH-1:0]   t1_bwB,
    output logic [NUMVBNK*PHYWDTH-1:0]   t1_doutA,
    output logic [NUMVBNK*PHYWDTH-1:0]   t1_doutB,
    output logic                         ready,
    output logic [2:0]                   err
);

    typedef enum logic {INIT, RUN} state_t;

    state_t             state, state_next;
    logic [BITSROW-1:0] cnt, cnt_next;
    logic [NUMVBNK-1:0] coll, bad;
    logic               early;

    if ((1 << BITVBNK) < NUMVBNK) begin : g_cfg_error
        $error("BITVBNK is too narrow to number NUMVBNK banks");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (state == INIT) begin
            cnt_next = cnt + 1'b1;
            if (cnt == BITSROW'(NUMSROW - 1)) begin
                state_next = RUN;
                cnt_next   = '0;
            end
        end
    end

    assign ready = (state == RUN);
    assign early = !ready && (|{t1_readA, t1_readB, t1_writeA, t1_writeB});

    always_ff @(posedge clk) begin
        if (rst) err <= '0;
        else     err <= err | {|bad, |coll, early};
    end

    for (genvar b = 0; b < NUMVBNK; b++) begin : g_bank
        logic [BITSROW-1:0]            addr   [2];
        logic [PHYWDTH-1:0]            din    [2];
        logic [PHYWDTH-1:0]            bw     [2];
        logic [PHYWDTH-1:0]            old    [2];
        logic [PHYWDTH-1:0]            merged [2];
        logic [PHYWDTH-1:0]            rdata  [2];
        logic                          rd     [2];
        logic                          wr     [2];
        logic                          ok     [2];
        logic                          wr_en  [2];
        logic [DELAY-1:0]              vld    [2];
        logic [DELAY-1:0][PHYWDTH-1:0] pdat   [2];
        logic [PHYWDTH-1:0]            mem    [NUMSROW];
        logic                          same_row;

        assign addr[0] = t1_addrA[b*BITSROW +: BITSROW];
        assign addr[1] = t1_addrB[b*BITSROW +: BITSROW];
        assign din[0]  = t1_dinA[b*PHYWDTH +: PHYWDTH];
        assign din[1]  = t1_dinB[b*PHYWDTH +: PHYWDTH];
        assign bw[0]   = t1_bwA[b*PHYWDTH +: PHYWDTH];
        assign bw[1]   = t1_bwB[b*PHYWDTH +: PHYWDTH];
        assign rd[0]   = t1_readA[b];
        assign rd[1]   = t1_readB[b];
        assign wr[0]   = t1_writeA[b];
        assign wr[1]   = t1_writeB[b];

        if (NUMSROW < (1 << BITSROW)) begin : g_range
            assign ok[0] = addr[0] < BITSROW'(NUMSROW);
            assign ok[1] = addr[1] < BITSROW'(NUMSROW);
        end else begin : g_full
            assign ok[0] = 1'b1;
            assign ok[1] = 1'b1;
        end

        assign same_row = (addr[0] == addr[1]);
        assign old[0]   = mem[addr[0]];
        assign old[1]   = mem[addr[1]];
        assign wr_en[0] = ready && wr[0] && ok[0];
        assign wr_en[1] = ready && wr[1] && ok[1];
        assign rdata[0] = ok[0] ? old[0] : '0;
        assign rdata[1] = ok[1] ? old[1] : '0;

        // Port B merges on top of port A's result when both hit the same row, so B wins overlaps.
        assign merged[0] = (old[0] & ~bw[0]) | (din[0] & bw[0]);
        assign merged[1] = (((wr_en[0] && same_row) ? merged[0] : old[1]) & ~bw[1]) | (din[1] & bw[1]);

        assign coll[b] = ready && same_row &&
                         ((wr[0] && wr[1]) || (rd[0] && wr[1]) || (rd[1] && wr[0]));
        assign bad[b]  = ready && ((rd[0] && wr[0]) || (rd[1] && wr[1]) ||
                                   ((rd[0] || wr[0]) && !ok[0]) || ((rd[1] || wr[1]) && !ok[1]));

        // NOTE: the array has no reset; the INIT sweep is what gives it defined contents.
        always_ff @(posedge clk) begin
            if (!rst) begin
                if (!ready) begin
                    mem[cnt] <= '0;
                end else begin
                    if (wr_en[0]) mem[addr[0]] <= merged[0];
                    if (wr_en[1]) mem[addr[1]] <= merged[1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld[0] <= '0;
                vld[1] <= '0;
            end else begin
                vld[0] <= (vld[0] << 1) | DELAY'(ready && rd[0]);
                vld[1] <= (vld[1] << 1) | DELAY'(ready && rd[1]);
            end
        end

        // Data stages need no reset: the valid bits gate what reaches dout.
        always_ff @(posedge clk) begin
            pdat[0] <= (pdat[0] << PHYWDTH) | (DELAY*PHYWDTH)'(rdata[0]);
            pdat[1] <= (pdat[1] << PHYWDTH) | (DELAY*PHYWDTH)'(rdata[1]);
        end

        assign t1_doutA[b*PHYWDTH +: PHYWDTH] = vld[0][DELAY-1] ? pdat[0][DELAY-1] : '0;
        assign t1_doutB[b*PHYWDTH +: PHYWDTH] = vld[1][DELAY-1] ? pdat[1][DELAY-1] : '0;
    end

endmodule

// File: tb/tb_algo_2rw_b740_t1_mem.sv
// Self-checking bench for algo_2rw_b740_t1_mem: a row-level memory model with a cycle-indexed
// read schedule is compared every cycle, plus directed scenarios with literal expectations.
module tb_algo_2rw_b740_t1_mem;

    localparam int NUMVBNK = 4;
    localparam int BITVBNK = 2;
    localparam int NUMSROW = 4096;
    localparam int BITSROW = 12;
    localparam int PHYWDTH = 128;
    localparam int DELAY   = 2;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [NUMVBNK-1:0]         t1_readA = '0, t1_readB = '0, t1_writeA = '0, t1_writeB = '0;
    logic [NUMVBNK*BITSROW-1:0] t1_addrA = '0, t1_addrB = '0;
    logic [NUMVBNK*PHYWDTH-1:0] t1_dinA = '0, t1_dinB = '0, t1_bwA = '0, t1_bwB = '0;
    logic [NUMVBNK*PHYWDTH-1:0] t1_doutA, t1_doutB;
    logic                       ready;
    logic [2:0]                 err;

    algo_2rw_b740_t1_mem #(
        .NUMVBNK(NUMVBNK), .BITVBNK(BITVBNK), .NUMSROW(NUMSROW),
        .BITSROW(BITSROW), .PHYWDTH(PHYWDTH), .DELAY(DELAY)
    ) dut (
        .clk(clk), .rst(rst),
        .t1_readA(t1_readA), .t1_readB(t1_readB),
        .t1_writeA(t1_writeA), .t1_writeB(t1_writeB),
        .t1_addrA(t1_addrA), .t1_addrB(t1_addrB),
        .t1_dinA(t1_dinA), .t1_dinB(t1_dinB),
        .t1_bwA(t1_bwA), .t1_bwB(t1_bwB),
        .t1_doutA(t1_doutA), .t1_doutB(t1_doutB),
        .ready(ready), .err(err)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [PHYWDTH-1:0] got, input logic [PHYWDTH-1:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // ---------------- model ----------------
    logic [PHYWDTH-1:0] mdl_mem [int];
    logic [PHYWDTH-1:0] sched   [longint];
    logic [2:0]         mdl_err = '0;
    int                 sweep_left = 0;
    longint             cyc = 0;
    bit                 live = 1'b0;

    function automatic logic in_rd(int p, int b);
        return (p == 0) ? t1_readA[b] : t1_readB[b];
    endfunction
    function automatic logic in_wr(int p, int b);
        return (p == 0) ? t1_writeA[b] : t1_writeB[b];
    endfunction
    function automatic int in_addr(int p, int b);
        return (p == 0) ? int'(t1_addrA[b*BITSROW +: BITSROW]) : int'(t1_addrB[b*BITSROW +: BITSROW]);
    endfunction
    function automatic logic [PHYWDTH-1:0] in_din(int p, int b);
        return (p == 0) ? t1_dinA[b*PHYWDTH +: PHYWDTH] : t1_dinB[b*PHYWDTH +: PHYWDTH];
    endfunction
    function automatic logic [PHYWDTH-1:0] in_bw(int p, int b);
        return (p == 0) ? t1_bwA[b*PHYWDTH +: PHYWDTH] : t1_bwB[b*PHYWDTH +: PHYWDTH];
    endfunction
    function automatic logic [PHYWDTH-1:0] mrd(int b, int row);
        int k = b * NUMSROW + row;
        return mdl_mem.exists(k) ? mdl_mem[k] : '0;
    endfunction
    function automatic longint skey(longint c, int p, int b);
        return c * 2 * NUMVBNK + longint'(p * NUMVBNK + b);
    endfunction
    function automatic logic [PHYWDTH-1:0] dslice(int p, int b);
        return (p == 0) ? t1_doutA[b*PHYWDTH +: PHYWDTH] : t1_doutB[b*PHYWDTH +: PHYWDTH];
    endfunction

    always @(posedge clk) begin : model
        int a [2];
        logic [PHYWDTH-1:0] v;
        if (rst) begin
            live = 1'b1;
            mdl_mem.delete();
            sched.delete();
            mdl_err = '0;
            sweep_left = NUMSROW;
        end else if (live) begin
            if (sweep_left != 0) begin
                if (|{t1_readA, t1_readB, t1_writeA, t1_writeB}) mdl_err[0] = 1'b1;
            end else begin
                for (int b = 0; b < NUMVBNK; b++) begin
                    a[0] = in_addr(0, b);
                    a[1] = in_addr(1, b);
                    if (a[0] == a[1] && ((in_wr(0, b) && in_wr(1, b)) || (in_rd(0, b) && in_wr(1, b)) ||
                                         (in_rd(1, b) && in_wr(0, b))))
                        mdl_err[1] = 1'b1;
                    for (int p = 0; p < 2; p++) begin
                        if (in_rd(p, b) && in_wr(p, b)) mdl_err[2] = 1'b1;
                        if ((in_rd(p, b) || in_wr(p, b)) && a[p] >= NUMSROW) mdl_err[2] = 1'b1;
                        if (in_rd(p, b)) sched[skey(cyc + DELAY, p, b)] = (a[p] < NUMSROW) ? mrd(b, a[p]) : '0;
                    end
                    for (int p = 0; p < 2; p++) begin
                        if (in_wr(p, b) && a[p] < NUMSROW) begin
                            v = mrd(b, a[p]);
                            mdl_mem[b * NUMSROW + a[p]] = (v & ~in_bw(p, b)) | (in_din(p, b) & in_bw(p, b));
                        end
                    end
                end
            end
            if (sweep_left > 0) sweep_left--;
        end
        cyc++;
    end

    always @(negedge clk) begin : compare
        longint k;
        logic [PHYWDTH-1:0] want;
        if (live) begin
            check("ready", PHYWDTH'(ready), PHYWDTH'(sweep_left == 0));
            check("err", PHYWDTH'(err), PHYWDTH'(mdl_err));
            for (int p = 0; p < 2; p++) begin
                for (int b = 0; b < NUMVBNK; b++) begin
                    k = skey(cyc, p, b);
                    want = sched.exists(k) ? sched[k] : '0;
                    check($sformatf("dout%s[%0d]", (p == 0) ? "A" : "B", b), dslice(p, b), want);
                    if (sched.exists(k)) sched.delete(k);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clr();
        t1_readA = '0; t1_readB = '0; t1_writeA = '0; t1_writeB = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic wr(input int p, input int b, input int row,
                      input logic [PHYWDTH-1:0] d, input logic [PHYWDTH-1:0] m);
        if (p == 0) begin
            t1_writeA[b] = 1'b1;
            t1_addrA[b*BITSROW +: BITSROW] = BITSROW'(row);
            t1_dinA[b*PHYWDTH +: PHYWDTH] = d;
            t1_bwA[b*PHYWDTH +: PHYWDTH] = m;
        end else begin
            t1_writeB[b] = 1'b1;
            t1_addrB[b*BITSROW +: BITSROW] = BITSROW'(row);
            t1_dinB[b*PHYWDTH +: PHYWDTH] = d;
            t1_bwB[b*PHYWDTH +: PHYWDTH] = m;
        end
    endtask

    task automatic rd(input int p, input int b, input int row);
        if (p == 0) begin
            t1_readA[b] = 1'b1;
            t1_addrA[b*BITSROW +: BITSROW] = BITSROW'(row);
        end else begin
            t1_readB[b] = 1'b1;
            t1_addrB[b*BITSROW +: BITSROW] = BITSROW'(row);
        end
    endtask

    // Holds rst for two edges, releases it, and counts not-ready cycles (bounded).
    task automatic do_reset(input bit early_write);
        int n = 0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        while (!ready && n < 5000) begin
            n++;
            if (early_write && n == 10) wr(0, 2, 3, '1, '1);
            tick();
        end
        check("sweep_len", PHYWDTH'(n), PHYWDTH'(NUMSROW));
    endtask

    initial begin
        logic [PHYWDTH-1:0] lit;
        clr();
        do_reset(1'b0);

        // Boundary row after sweep reads zero, no errors.
        rd(1, 3, 4095);
        tick(); tick();
        check("lit_row4095", dslice(1, 3), '0);
        check("lit_err_clean", PHYWDTH'(err), '0);

        // Bit-write: ones, then clear low byte only.
        wr(0, 1, 5, '1, '1);
        tick();
        wr(0, 1, 5, '0, 128'hFF);
        tick();
        rd(0, 1, 5);
        tick(); tick();
        lit = ~128'hFF;
        check("lit_bitwrite", dslice(0, 1), lit);
        tick();
        check("lit_bitwrite_gone", dslice(0, 1), '0);

        // Same-row A/B write collision: B wins low byte.
        wr(0, 0, 7, 128'hAAAA, 128'hFFFF);
        wr(1, 0, 7, 128'h5555, 128'h00FF);
        tick();
        rd(0, 0, 7);
        tick(); tick();
        check("lit_collision", dslice(0, 0), 128'hAA55);
        check("lit_err_coll", PHYWDTH'(err), PHYWDTH'(3'b010));

        // Read-before-write across ports.
        wr(0, 0, 9, 128'h1, '1);
        tick();
        rd(0, 0, 9);
        wr(1, 0, 9, 128'h2, '1);
        tick();
        rd(0, 0, 9);
        tick();
        check("lit_rbw_old", dslice(0, 0), 128'h1);
        tick();
        check("lit_rbw_new", dslice(0, 0), 128'h2);

        // Back-to-back pipeline on bank 2.
        for (int i = 0; i < 10; i++) begin
            wr(0, 2, i, PHYWDTH'(i), '1);
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            if (i < 10) rd(0, 2, i);
            tick();
            if (i >= 1 && i <= 10) check($sformatf("lit_pipe%0d", i - 1), dslice(0, 2), PHYWDTH'(i - 1));
            if (i == 11) check("lit_pipe_tail", dslice(0, 2), '0);
        end

        // Read and write on one port/bank in one cycle.
        rd(1, 3, 100);
        wr(1, 3, 100, '1, '1);
        tick(); tick();
        check("lit_samport_old", dslice(1, 3), '0);
        check("lit_err_bad", PHYWDTH'(err), PHYWDTH'(3'b110));
        rd(1, 3, 100);
        tick(); tick();
        lit = '1;
        check("lit_samport_new", dslice(1, 3), lit);

        // Reset with a read in flight, then an access during the sweep.
        rd(0, 2, 5);
        tick();
        rst = 1'b1;
        tick();
        check("lit_flush_dout", dslice(0, 2), '0);
        check("lit_flush_err", PHYWDTH'(err), '0);
        check("lit_flush_ready", PHYWDTH'(ready), '0);
        do_reset(1'b1);
        check("lit_err_early", PHYWDTH'(err), PHYWDTH'(3'b001));
        rd(0, 2, 3);
        tick(); tick();
        check("lit_early_dropped", dslice(0, 2), '0);
        rd(0, 2, 5);
        tick(); tick();
        check("lit_swept_row5", dslice(0, 2), '0);

        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got still running want finished");
        $fatal(1);
    end

endmodule
